pokemon_led_sequencer: RTL and testbench
========================================

# pokemon_led_sequencer

Hardware LED pattern scheduler sitting between the game logic and the 14-bit LED PIO slave in the Pokemon SoC. It holds a CPU-programmed base pattern and, on a hardware event request (hit, level-up, capture), plays a timed flash sequence. It then drives the PIO's Avalon slave port (address 0 write) as its sole master. The CPU configures it through its own small Avalon-MM slave.

## Interface
Parameters:
- LED_W, 14, LED pattern width; must match the PIO width
- TIMER_W, 24, width of the phase-period register and timer

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  2  config register select
- avs_chipselect  in  1  config slave select
- avs_write_n  in  1  active-low write strobe
- avs_writedata  in  32  config write data
- avs_readdata  out  32  config read data, combinational, zero wait states
- event_req  in  1  level request to start a flash sequence
- event_pattern  in  LED_W  flash pattern, sampled on accept
- event_ack  out  1  one-cycle pulse when a request is accepted
- pio_address  out  2  to PIO address; constant 0
- pio_chipselect  out  1  to PIO chipselect, registered
- pio_write_n  out  1  to PIO write_n, registered
- pio_writedata  out  32  to PIO writedata, {zero-pad, pattern}, registered
- busy  out  1  high whenever state is not IDLE

Clock and reset: single clock. Reset is asynchronous and active-low.

## Operation
Registers, all reset to 0:
- 0 BASE[LED_W-1:0]: idle pattern
- 1 PERIOD[TIMER_W-1:0]: cycles per flash phase; a value of 0 is treated as 1
- 2 CTRL: [7:0] COUNT (flashes per event), [8] EN
- 3 STATUS (read): [0] busy, [1] pending (0 without the macro), [15:8] remaining flashes. A write with bit0=1 is ABORT.
- Reads of unimplemented bits return 0.

FSM states: IDLE, ON, OFF.
- IDLE → ON when event_req=1 and EN=1 and COUNT≠0. On this transition: latch event_pattern, pulse event_ack, load remaining=COUNT and timer=PERIOD.
- ON → OFF when the timer expires. The timer reloads with PERIOD.
- OFF → ON when the timer expires and remaining>1. remaining decrements.
- OFF → IDLE when the timer expires and remaining=1.
- ABORT in any state → IDLE on the next edge. remaining is cleared and the pending slot is cleared.
- Clearing EN does not stop a running sequence. It only blocks new starts.
- In ON or OFF, event_req is not acked (but see Configuration).

Desired pattern: latched event pattern in ON; BASE in IDLE and OFF. A BASE write during a sequence becomes visible in the next OFF or IDLE.

PIO write engine:
- A shadow register holds the last value written to the PIO; it resets to 0, matching the PIO reset.
- On each edge where desired≠shadow: assert pio_chipselect=1 and pio_write_n=0 for exactly one cycle, drive the desired value on pio_writedata, and update shadow.
- Otherwise pio_chipselect=0 and pio_write_n=1.
- No write is issued when the pattern is unchanged, including ON with a flash pattern equal to BASE.

Output reset values: pio_chipselect=0, pio_write_n=1, pio_writedata=0, pio_address=0, event_ack=0, busy=0.

## Timing
- Accept: event_ack is high in the cycle after the edge where event_req is sampled in IDLE. busy rises on the same edge.
- Each ON and OFF phase lasts exactly max(PERIOD,1) cycles.
- Pattern change to PIO write: the PIO write strobe is asserted 1 cycle after the state change. The PIO out_port updates 1 cycle after that, 2 cycles total.
- A full sequence occupies 2·COUNT·max(PERIOD,1) cycles from accept to IDLE.
- A simultaneous CPU ABORT and event_req in IDLE: ABORT wins and no accept occurs.
- A config write to PERIOD takes effect at the next timer reload.
- Asynchronous reset mid-sequence returns all state to reset values. No PIO write is issued, since the PIO is reset by the same reset.

## Configuration
- POKEMON_LED_SEQ_QUEUE_EN defined: a one-deep pending slot is added.
  - event_req while busy with the slot empty is acked and stores event_pattern; STATUS[1]=1.
  - On OFF → IDLE with the slot full, the FSM goes directly OFF → ON with the stored pattern, remaining=COUNT, and the slot cleared.
  - A request while the slot is full is not acked.
- Undefined: there is no slot, requests while busy are never acked, and STATUS[1] reads 0.

## Test plan
- Reset, write BASE=0x0005: one PIO write of 0x00000005 two cycles after the config write. No further writes.
- PERIOD=4, COUNT=2, EN=1, event_pattern=0x3FFF:
  - PIO writes 0x3FFF and 0x0005 alternate with 4-cycle spacing, 4 writes total.
  - busy is high for 16 cycles.
  - event_ack is a single 1-cycle pulse.
- PERIOD=0, COUNT=1: phases of 1 cycle each; writes 0x3FFF then 0x0005 on consecutive cycles.
- ABORT written mid-ON with PERIOD=100: IDLE on the next edge, then a single PIO write restoring BASE. STATUS reads 0.
- event_pattern equal to BASE: the sequence runs (busy high for 2·COUNT·PERIOD cycles) with zero PIO writes.
- With POKEMON_LED_SEQ_QUEUE_EN, a second request with pattern 0x00AA during the first sequence:
  - The second request is acked immediately and STATUS[1]=1.
  - The second sequence starts with no IDLE cycle between sequences.
  - A third request during the run is not acked.

Source files
------------

// File: rtl/pokemon_led_sequencer_if.sv
`timescale 1ns/1ps
// pokemon_led_sequencer_if: CPU config slave port plus the PIO master port of the LED sequencer.
interface pokemon_led_sequencer_if;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  // Sequencer side: config slave in, PIO master out.
  modport slave (
    input  avs_address, avs_chipselect, avs_write_n, avs_writedata,
    output avs_readdata,
    output pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

  // CPU / PIO side of the same wires.
  modport master (
    output avs_address, avs_chipselect, avs_write_n, avs_writedata,
    input  avs_readdata,
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata
  );
endinterface

// File: rtl/pokemon_led_sequencer.sv
`timescale 1ns/1ps
// pokemon_led_sequencer: holds a CPU base LED pattern, plays timed flash sequences on
// hardware events and mirrors the wanted pattern into the LED PIO with minimal writes.
// Optional feature macro: POKEMON_LED_SEQ_QUEUE_EN adds a one-deep pending event slot.
module pokemon_led_sequencer #(
  parameter int unsigned LED_W   = 14,
  parameter int unsigned TIMER_W = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pokemon_led_sequencer_if.slave bus,
  input  logic                   event_req,
  input  logic [LED_W-1:0]       event_pattern,
  output logic                   event_ack,
  output logic                   busy
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LED_W-1:0]   base_q, base_d;
  logic [LED_W-1:0]   flash_q, flash_d;
  logic [LED_W-1:0]   shadow_q, shadow_d;
  logic [LED_W-1:0]   desired_c;
  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] period_eff_c;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               en_q, en_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               pio_cs_q, pio_cs_d;
  logic               pio_wr_n_q, pio_wr_n_d;
  logic [DATA_W-1:0]  pio_wdata_q, pio_wdata_d;
  logic               cfg_wr_c, abort_c, can_start_c, timer_done_c, pending_c;
  logic               unused_wdata;

`ifdef POKEMON_LED_SEQ_QUEUE_EN
  logic               pend_q, pend_d;
  logic [LED_W-1:0]   pend_pat_q, pend_pat_d;
  assign pending_c = pend_q;
`else
  assign pending_c = 1'b0;
`endif

  assign cfg_wr_c     = bus.avs_chipselect & ~bus.avs_write_n;
  assign abort_c      = cfg_wr_c && (bus.avs_address == 2'd3) && bus.avs_writedata[0];
  assign can_start_c  = event_req && en_q && (count_q != '0);
  assign period_eff_c = (period_q == '0) ? TIMER_W'(1) : period_q;
  assign timer_done_c = (timer_q <= TIMER_W'(1));
  assign desired_c    = (state_q == S_ON) ? flash_q : base_q;
  assign unused_wdata = ^bus.avs_writedata;

  // Config register writes.
  always_comb begin
    base_d   = base_q;
    period_d = period_q;
    count_d  = count_q;
    en_d     = en_q;
    if (cfg_wr_c) begin
      case (bus.avs_address)
        2'd0: base_d = bus.avs_writedata[LED_W-1:0];
        2'd1: period_d = bus.avs_writedata[TIMER_W-1:0];
        2'd2: begin
          count_d = bus.avs_writedata[CNT_W-1:0];
          en_d    = bus.avs_writedata[8];
        end
        default: ;
      endcase
    end
  end

  // Flash sequencer next state; abort overrides everything including a same-cycle start.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    flash_d     = flash_q;
    ack_d       = 1'b0;
`ifdef POKEMON_LED_SEQ_QUEUE_EN
    pend_d      = pend_q;
    pend_pat_d  = pend_pat_q;
`endif
    if (abort_c) begin
      state_d     = S_IDLE;
      remaining_d = '0;
      timer_d     = '0;
`ifdef POKEMON_LED_SEQ_QUEUE_EN
      pend_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (can_start_c) begin
            state_d     = S_ON;
            flash_d     = event_pattern;
            ack_d       = 1'b1;
            remaining_d = count_q;
            timer_d     = period_eff_c;
          end
        end
        S_ON: begin
          if (timer_done_c) begin
            state_d = S_OFF;
            timer_d = period_eff_c;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        S_OFF: begin
          if (timer_done_c) begin
            timer_d = period_eff_c;
            if (remaining_q > CNT_W'(1)) begin
              state_d     = S_ON;
              remaining_d = remaining_q - CNT_W'(1);
            end
`ifdef POKEMON_LED_SEQ_QUEUE_EN
            else if (pend_q) begin
              state_d     = S_ON;
              flash_d     = pend_pat_q;
              remaining_d = count_q;
              pend_d      = 1'b0;
            end
`endif
            else begin
              state_d     = S_IDLE;
              remaining_d = '0;
              timer_d     = '0;
            end
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
`ifdef POKEMON_LED_SEQ_QUEUE_EN
      // A request arriving on the very edge a sequence ends restarts directly instead of parking.
      if ((state_q != S_IDLE) && can_start_c && !pend_q) begin
        ack_d = 1'b1;
        if (state_d == S_IDLE) begin
          state_d     = S_ON;
          flash_d     = event_pattern;
          remaining_d = count_q;
          timer_d     = period_eff_c;
        end else begin
          pend_d     = 1'b1;
          pend_pat_d = event_pattern;
        end
      end
`endif
    end
  end

  // PIO write engine: one strobe per change of the desired pattern against the shadow copy.
  always_comb begin
    shadow_d    = desired_c;
    pio_cs_d    = (desired_c != shadow_q);
    pio_wr_n_d  = ~pio_cs_d;
    pio_wdata_d = pio_wdata_q;
    if (pio_cs_d) pio_wdata_d = DATA_W'(desired_c);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      period_q    <= '0;
      count_q     <= '0;
      en_q        <= 1'b0;
      flash_q     <= '0;
      timer_q     <= '0;
      remaining_q <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      shadow_q    <= '0;
      pio_cs_q    <= 1'b0;
      pio_wr_n_q  <= 1'b1;
      pio_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      period_q    <= period_d;
      count_q     <= count_d;
      en_q        <= en_d;
      flash_q     <= flash_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      shadow_q    <= shadow_d;
      pio_cs_q    <= pio_cs_d;
      pio_wr_n_q  <= pio_wr_n_d;
      pio_wdata_q <= pio_wdata_d;
    end
  end

`ifdef POKEMON_LED_SEQ_QUEUE_EN
  // Pending event slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      pend_pat_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_pat_q <= pend_pat_d;
    end
  end
`endif

  // Zero-wait-state config readback.
  always_comb begin
    bus.avs_readdata = '0;
    case (bus.avs_address)
      2'd0:    bus.avs_readdata = DATA_W'(base_q);
      2'd1:    bus.avs_readdata = DATA_W'(period_q);
      2'd2:    bus.avs_readdata = DATA_W'({en_q, count_q});
      default: bus.avs_readdata = DATA_W'({remaining_q, 6'd0, pending_c, busy_q});
    endcase
  end

  assign event_ack          = ack_q;
  assign busy               = busy_q;
  assign bus.pio_address    = 2'd0;
  assign bus.pio_chipselect = pio_cs_q;
  assign bus.pio_write_n    = pio_wr_n_q;
  assign bus.pio_writedata  = pio_wdata_q;
endmodule

// File: tb/tb_pokemon_led_sequencer.sv
`timescale 1ns/1ps
// Bench for pokemon_led_sequencer: randomized flash sequences checked against a
// cycle-arithmetic model of the expected PIO write trace, ack pulses and busy window.
module tb_pokemon_led_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        event_req = 1'b0;
  logic [13:0] event_pattern = '0;
  logic        event_ack, busy;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] m_base = '0;

  int          wr_cyc[$];
  logic [31:0] wr_dat[$];
  int          ack_cyc[$];
  int          busy_cnt = 0;
  int          busy_first = -1;
  int          exp_cyc[$];
  logic [31:0] exp_dat[$];

  pokemon_led_sequencer_if bus ();

  pokemon_led_sequencer #(.LED_W(14), .TIMER_W(24)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .event_req     (event_req),
    .event_pattern (event_pattern),
    .event_ack     (event_ack),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe PIO strobes, acks and busy at the falling edge.
  always @(negedge clk) begin
    if (bus.pio_chipselect && !bus.pio_write_n) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(bus.pio_writedata);
    end
    if (event_ack) ack_cyc.push_back(cyc);
    if (busy) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_cnt++;
    end
  end

  task automatic clear_mon();
    wr_cyc.delete(); wr_dat.delete(); ack_cyc.delete();
    exp_cyc.delete(); exp_dat.delete();
    busy_cnt = 0; busy_first = -1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data, output int e);
    @(posedge clk); #1;
    bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0;
    bus.avs_address = addr; bus.avs_writedata = data;
    @(posedge clk); #1;
    e = cyc;
    bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
  endtask

  task automatic start_event(input logic [13:0] pat, output int a);
    @(posedge clk); #1;
    event_req = 1'b1; event_pattern = pat;
    @(posedge clk); #1;
    a = cyc;
    event_req = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = addr;
    #1 d = bus.avs_readdata;
  endtask

  // Model: ON phases begin at a+2kN, OFF at a+(2k+1)N; each change is strobed one cycle later.
  task automatic append_seq(input int a, input logic [13:0] pat, input int cnt, input int n);
    if (pat != m_base) begin
      for (int k = 0; k < cnt; k++) begin
        exp_cyc.push_back(a + 2*k*n + 1);       exp_dat.push_back({18'd0, pat});
        exp_cyc.push_back(a + (2*k+1)*n + 1);   exp_dat.push_back({18'd0, m_base});
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int e;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), d);
      vectors++;
      if (d !== 32'd0) begin miscompares++; $display("FAIL reset_reg%0d got %h want 0", i, d); end
    end
    vectors++;
    if (bus.pio_chipselect !== 1'b0 || bus.pio_write_n !== 1'b1 || bus.pio_writedata !== 32'd0 ||
        bus.pio_address !== 2'd0 || event_ack !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got cs=%b wn=%b wd=%h ad=%0d ack=%b busy=%b want 0 1 0 0 0 0",
               bus.pio_chipselect, bus.pio_write_n, bus.pio_writedata, bus.pio_address, event_ack, busy);
    end
    clear_mon();
    cfg_write(2'd0, 32'h5, e);
    m_base = 14'h5;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (wr_cyc.size() !== 1) begin
      miscompares++; $display("FAIL base_write_count got %0d want 1", wr_cyc.size());
    end else begin
      vectors++;
      if (wr_cyc[0] !== e + 1 || wr_dat[0] !== 32'h5) begin
        miscompares++;
        $display("FAIL base_write got cyc %0d data %h want cyc %0d data 00000005", wr_cyc[0], wr_dat[0], e + 1);
      end
    end
  endtask

  task automatic test_sequence(input string name, input logic [13:0] pat, input int per, input int cnt);
    int e, a, n;
    logic [31:0] d;
    n = (per == 0) ? 1 : per;
    cfg_write(2'd1, 32'(per), e);
    cfg_write(2'd2, 32'h100 | 32'(cnt), e);
    repeat (3) @(posedge clk);
    clear_mon();
    start_event(pat, a);
    repeat (2*cnt*n + 4) @(posedge clk);
    #1;
    append_seq(a, pat, cnt, n);
    vectors++;
    if (wr_cyc.size() !== exp_cyc.size()) begin
      miscompares++;
      $display("FAIL %s write_count got %0d want %0d", name, wr_cyc.size(), exp_cyc.size());
    end else begin
      for (int i = 0; i < exp_cyc.size(); i++) begin
        vectors++;
        if (wr_cyc[i] !== exp_cyc[i] || wr_dat[i] !== exp_dat[i]) begin
          miscompares++;
          $display("FAIL %s write%0d got cyc %0d data %h want cyc %0d data %h",
                   name, i, wr_cyc[i], wr_dat[i], exp_cyc[i], exp_dat[i]);
        end
      end
    end
    vectors++;
    if (ack_cyc.size() !== 1 || ack_cyc[0] !== a) begin
      miscompares++;
      $display("FAIL %s ack got %0d pulses (first cyc %0d) want 1 at cyc %0d",
               name, ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, a);
    end
    vectors++;
    if (busy_cnt !== 2*cnt*n || busy_first !== a) begin
      miscompares++;
      $display("FAIL %s busy got %0d cycles from %0d want %0d from %0d", name, busy_cnt, busy_first, 2*cnt*n, a);
    end
    read_reg(2'd3, d);
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL %s status_end got %h want 0", name, d); end
  endtask

  task automatic test_abort();
    int e, a, w;
    logic [31:0] d;
    cfg_write(2'd1, 32'd100, e);
    cfg_write(2'd2, 32'h102, e);
    repeat (2) @(posedge clk);
    clear_mon();
    start_event(14'h3FFF, a);
    repeat (10) @(posedge clk);
    cfg_write(2'd3, 32'h1, w);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (wr_cyc.size() !== 2) begin
      miscompares++; $display("FAIL abort write_count got %0d want 2", wr_cyc.size());
    end else begin
      vectors++;
      if (wr_cyc[0] !== a + 1 || wr_dat[0] !== 32'h3FFF || wr_cyc[1] !== w + 1 || wr_dat[1] !== {18'd0, m_base}) begin
        miscompares++;
        $display("FAIL abort writes got %0d:%h %0d:%h want %0d:00003fff %0d:%h",
                 wr_cyc[0], wr_dat[0], wr_cyc[1], wr_dat[1], a + 1, w + 1, {18'd0, m_base});
      end
    end
    vectors++;
    if (busy_cnt !== w - a) begin
      miscompares++; $display("FAIL abort busy got %0d want %0d", busy_cnt, w - a);
    end
    read_reg(2'd3, d);
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL abort status got %h want 0", d); end
  endtask

  task automatic test_abort_vs_req();
    int e;
    cfg_write(2'd2, 32'h101, e);
    repeat (2) @(posedge clk);
    clear_mon();
    @(posedge clk); #1;
    bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0; bus.avs_address = 2'd3; bus.avs_writedata = 32'h1;
    event_req = 1'b1; event_pattern = 14'h1234;
    @(posedge clk); #1;
    bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1; event_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (ack_cyc.size() !== 0 || busy_cnt !== 0 || wr_cyc.size() !== 0) begin
      miscompares++;
      $display("FAIL abort_vs_req got acks %0d busy %0d writes %0d want 0 0 0", ack_cyc.size(), busy_cnt, wr_cyc.size());
    end
  endtask

  task automatic test_gating();
    int e, a;
    cfg_write(2'd1, 32'd2, e);
    cfg_write(2'd2, 32'h003, e);
    clear_mon();
    start_event(14'h0F0F, a);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (ack_cyc.size() !== 0 || busy_cnt !== 0) begin
      miscompares++; $display("FAIL en_off got acks %0d busy %0d want 0 0", ack_cyc.size(), busy_cnt);
    end
    cfg_write(2'd2, 32'h100, e);
    clear_mon();
    start_event(14'h0F0F, a);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (ack_cyc.size() !== 0 || busy_cnt !== 0) begin
      miscompares++; $display("FAIL count_zero got acks %0d busy %0d want 0 0", ack_cyc.size(), busy_cnt);
    end
  endtask

  task automatic test_busy_req();
    int e, a, r, r3, n, cnt, exp_busy;
    logic [31:0] d, exp_st;
    n = 4; cnt = 2;
    cfg_write(2'd1, 32'(n), e);
    cfg_write(2'd2, 32'h100 | 32'(cnt), e);
    repeat (2) @(posedge clk);
    clear_mon();
    start_event(14'h3FFF, a);
    start_event(14'h00AA, r);
    read_reg(2'd3, d);
    start_event(14'h0155, r3);
    repeat (4*cnt*n + 4) @(posedge clk);
    #1;
    append_seq(a, 14'h3FFF, cnt, n);
`ifdef POKEMON_LED_SEQ_QUEUE_EN
    append_seq(a + 2*cnt*n, 14'h00AA, cnt, n);
    exp_busy = 4*cnt*n;
    exp_st = 32'h0203;
    vectors++;
    if (ack_cyc.size() !== 2 || ack_cyc[1] !== r) begin
      miscompares++; $display("FAIL queue_ack got %0d acks want 2 (second at %0d)", ack_cyc.size(), r);
    end
`else
    exp_busy = 2*cnt*n;
    exp_st = 32'h0201;
    vectors++;
    if (ack_cyc.size() !== 1) begin
      miscompares++; $display("FAIL busy_req_ack got %0d acks want 1", ack_cyc.size());
    end
`endif
    vectors++;
    if (d !== exp_st) begin miscompares++; $display("FAIL busy_status got %h want %h", d, exp_st); end
    vectors++;
    if (busy_cnt !== exp_busy || busy_first !== a) begin
      miscompares++; $display("FAIL busy_req_busy got %0d from %0d want %0d from %0d", busy_cnt, busy_first, exp_busy, a);
    end
    vectors++;
    if (wr_cyc.size() !== exp_cyc.size()) begin
      miscompares++; $display("FAIL busy_req write_count got %0d want %0d", wr_cyc.size(), exp_cyc.size());
    end else begin
      for (int i = 0; i < exp_cyc.size(); i++) begin
        vectors++;
        if (wr_cyc[i] !== exp_cyc[i] || wr_dat[i] !== exp_dat[i]) begin
          miscompares++;
          $display("FAIL busy_req write%0d got cyc %0d data %h want cyc %0d data %h",
                   i, wr_cyc[i], wr_dat[i], exp_cyc[i], exp_dat[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int e;
    logic [13:0] pat;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        m_base = 14'($urandom);
        cfg_write(2'd0, {18'd0, m_base}, e);
        repeat (3) @(posedge clk);
      end
      pat = 14'($urandom);
      test_sequence($sformatf("rand%0d", it), pat, int'($urandom_range(0, 5)), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_reset_mid();
    int e, a;
    cfg_write(2'd1, 32'd10, e);
    cfg_write(2'd2, 32'h102, e);
    start_event(14'h2AAA ^ m_base, a);
    repeat (5) @(posedge clk);
    #2;
    clear_mon();
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.pio_chipselect !== 1'b0 || bus.pio_write_n !== 1'b1 || bus.pio_writedata !== 32'd0 ||
        event_ack !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got cs=%b wn=%b wd=%h ack=%b busy=%b want 0 1 0 0 0",
               bus.pio_chipselect, bus.pio_write_n, bus.pio_writedata, event_ack, busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_base = '0;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (wr_cyc.size() !== 0 || busy_cnt !== 0) begin
      miscompares++; $display("FAIL reset_mid_after got writes %0d busy %0d want 0 0", wr_cyc.size(), busy_cnt);
    end
  endtask

  initial begin
    int e;
    bus.avs_address = '0; bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1; bus.avs_writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_sequence("flash", 14'h3FFF, 4, 2);
    test_sequence("period_zero", 14'h3FFF, 0, 1);
    test_abort();
    test_abort_vs_req();
    test_gating();
    test_busy_req();
    test_sequence("same_pattern", m_base, 3, 2);
    test_random();
    test_reset_mid();
    cfg_write(2'd0, 32'h0, e);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
